// File: rtl/pid_multi.sv
// pid_multi: time-multiplexed PID controller serving NUM_CH channels with one
// shared multiplier. Each frame walks every channel through ERR, MP, MI, MD and
// OUT, then commits all staged outputs together in COMMIT.
module pid_multi #(
  parameter int NUM_CH  = 4,
  parameter int W       = 13,
  parameter int KW      = 13,
  parameter int SHW     = 4,
  parameter int PW      = 13,
  parameter int INT_LIM = 4095
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  sample_tick,
  input  logic [NUM_CH*W-1:0]   pos_d,
  input  logic [NUM_CH*W-1:0]   pos,
  input  logic [NUM_CH*KW-1:0]  kp_n,
  input  logic [NUM_CH*KW-1:0]  ki_n,
  input  logic [NUM_CH*KW-1:0]  kd_n,
  input  logic [NUM_CH*SHW-1:0] kp_d,
  input  logic [NUM_CH*SHW-1:0] ki_d,
  input  logic [NUM_CH*SHW-1:0] kd_d,
  input  logic [NUM_CH-1:0]     clear_int,
  output logic [NUM_CH*PW-1:0]  pwm,
  output logic [NUM_CH-1:0]     dir,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW  = $clog2(INT_LIM + 1) + 1;
  localparam int OW  = ((IW > W + 2) ? IW : W + 2) + 1;
  localparam int PRW = KW + 1 + OW;
  localparam int SW  = PRW + 2;
  localparam logic [CW-1:0]        LAST_CH  = CW'(NUM_CH - 1);
  localparam logic signed [OW-1:0] LIM_P    = OW'(INT_LIM);
  localparam logic signed [OW-1:0] LIM_N    = -LIM_P;
  localparam logic [SW-1:0]        PWM_MAXW = {{(SW-PW){1'b0}}, {PW{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MP, S_MI, S_MD, S_OUT, S_COMMIT
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0]          ch_q;
  logic [NUM_CH*W-1:0]    posD_q, pos_q;
  logic [NUM_CH*KW-1:0]   kpN_q, kiN_q, kdN_q;
  logic [NUM_CH*SHW-1:0]  kpD_q, kiD_q, kdD_q;
  logic [NUM_CH-1:0]      clr_q;
  logic signed [W:0]      errPrev_q [NUM_CH];
  logic signed [IW-1:0]   intAcc_q  [NUM_CH];
  logic signed [OW-1:0]   err_q, intv_q, deriv_q;
  logic signed [SW-1:0]   sum_q;
  logic [NUM_CH*PW-1:0]   stagePwm_q, pwm_q;
  logic [NUM_CH-1:0]      stageDir_q, dir_q;
  logic                   busy_q, done_q, overrun_q;

  logic [W-1:0]           chPosD, chPos;
  logic signed [W:0]      errNow;
  logic signed [OW-1:0]   errExt, prevExt, intBase, intSum, intClamped, derivNow;
  logic [KW-1:0]          gainN;
  logic [SHW-1:0]         gainSh;
  logic signed [OW-1:0]   mulX;
  logic signed [PRW-1:0]  mulA, mulB, product, term;
  logic signed [SW-1:0]   termExt;
  logic [SW-1:0]          sumAbs;
  logic [PW-1:0]          magNow;
  logic                   dirNow;

  // Error, clamped integrator and derivative for the channel being processed.
  assign chPosD     = posD_q[ch_q*W +: W];
  assign chPos      = pos_q[ch_q*W +: W];
  assign errNow     = $signed({1'b0, chPosD}) - $signed({1'b0, chPos});
  assign errExt     = {{(OW-W-1){errNow[W]}}, errNow};
  assign prevExt    = {{(OW-W-1){errPrev_q[ch_q][W]}}, errPrev_q[ch_q]};
  assign intBase    = clr_q[ch_q] ? '0 : {{(OW-IW){intAcc_q[ch_q][IW-1]}}, intAcc_q[ch_q]};
  assign intSum     = intBase + errExt;
  assign intClamped = (intSum > LIM_P) ? LIM_P : ((intSum < LIM_N) ? LIM_N : intSum);
  assign derivNow   = errExt - prevExt;

  // Select gain and operand for the single shared multiplier.
  always_comb begin
    gainN  = '0;
    gainSh = '0;
    mulX   = '0;
    case (state_q)
      S_MP: begin
        gainN  = kpN_q[ch_q*KW +: KW];
        gainSh = kpD_q[ch_q*SHW +: SHW];
        mulX   = err_q;
      end
      S_MI: begin
        gainN  = kiN_q[ch_q*KW +: KW];
        gainSh = kiD_q[ch_q*SHW +: SHW];
        mulX   = intv_q;
      end
      S_MD: begin
        gainN  = kdN_q[ch_q*KW +: KW];
        gainSh = kdD_q[ch_q*SHW +: SHW];
        mulX   = deriv_q;
      end
      default: ;
    endcase
  end

  assign mulA    = {{(OW+1){1'b0}}, gainN};
  assign mulB    = {{(KW+1){mulX[OW-1]}}, mulX};
  assign product = mulA * mulB;
  assign term    = product >>> gainSh;
  assign termExt = {{2{term[PRW-1]}}, term};

  assign sumAbs  = sum_q[SW-1] ? -sum_q : sum_q;
  assign magNow  = (sumAbs > PWM_MAXW) ? {PW{1'b1}} : sumAbs[PW-1:0];
  assign dirNow  = !sum_q[SW-1] && (sum_q != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a frame starts on an enabled tick; dropping enable aborts to IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (sample_tick) state_d = S_ERR;
        S_ERR:    state_d = S_MP;
        S_MP:     state_d = S_MI;
        S_MI:     state_d = S_MD;
        S_MD:     state_d = S_OUT;
        S_OUT:    state_d = (ch_q == LAST_CH) ? S_COMMIT : S_ERR;
        S_COMMIT: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: snapshot, per-channel history, accumulation, staging and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= '0;
      posD_q     <= '0;
      pos_q      <= '0;
      kpN_q      <= '0;
      kiN_q      <= '0;
      kdN_q      <= '0;
      kpD_q      <= '0;
      kiD_q      <= '0;
      kdD_q      <= '0;
      clr_q      <= '0;
      err_q      <= '0;
      intv_q     <= '0;
      deriv_q    <= '0;
      sum_q      <= '0;
      stagePwm_q <= '0;
      stageDir_q <= '0;
      pwm_q      <= '0;
      dir_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        errPrev_q[c] <= '0;
        intAcc_q[c]  <= '0;
      end
    end else begin
      done_q    <= 1'b0;
      overrun_q <= sample_tick && enable && (state_q != S_IDLE);
      busy_q    <= enable && (state_q != S_IDLE) && (state_q != S_COMMIT);
      if (!enable) begin
        pwm_q <= '0;
        dir_q <= '0;
        ch_q  <= '0;
        if (state_q != S_IDLE) begin
          for (int c = 0; c < NUM_CH; c++) begin
            errPrev_q[c] <= '0;
            intAcc_q[c]  <= '0;
          end
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sample_tick) begin
              posD_q <= pos_d;
              pos_q  <= pos;
              kpN_q  <= kp_n;
              kiN_q  <= ki_n;
              kdN_q  <= kd_n;
              kpD_q  <= kp_d;
              kiD_q  <= ki_d;
              kdD_q  <= kd_d;
              clr_q  <= clear_int;
              ch_q   <= '0;
            end
          end
          S_ERR: begin
            err_q           <= errExt;
            intv_q          <= intClamped;
            deriv_q         <= derivNow;
            intAcc_q[ch_q]  <= intClamped[IW-1:0];
            errPrev_q[ch_q] <= errNow;
            sum_q           <= '0;
          end
          S_MP, S_MI, S_MD: sum_q <= sum_q + termExt;
          S_OUT: begin
            stagePwm_q[ch_q*PW +: PW] <= magNow;
            stageDir_q[ch_q]          <= dirNow;
            if (ch_q != LAST_CH) ch_q <= ch_q + CW'(1);
          end
          S_COMMIT: begin
            pwm_q  <= stagePwm_q;
            dir_q  <= stageDir_q;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pwm     = pwm_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pid_multi.sv
// tb_pid_multi: scoreboard bench for pid_multi; a behavioural PID model pushes
// the expected committed outputs when a frame is started, and every done pulse
// pops and compares them.
module tb_pid_multi;

  localparam int NCH = 4;
  localparam int W   = 13;
  localparam int KW  = 13;
  localparam int SHW = 4;
  localparam int PW  = 13;
  localparam int LIM = 250;
  localparam longint PMAX = 8191;

  typedef struct {
    logic [NCH*PW-1:0] pwm;
    logic [NCH-1:0]    dir;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                enable;
  logic                sample_tick;
  logic [NCH*W-1:0]    pos_d, pos;
  logic [NCH*KW-1:0]   kp_n, ki_n, kd_n;
  logic [NCH*SHW-1:0]  kp_d, ki_d, kd_d;
  logic [NCH-1:0]      clear_int;
  logic [NCH*PW-1:0]   pwm;
  logic [NCH-1:0]      dir;
  logic                busy, done, overrun;

  exp_t   sbQ[$];
  longint mInt  [NCH];
  longint mPrev [NCH];
  int     checkCount = 0;
  int     passCount  = 0;

  pid_multi #(
    .NUM_CH(NCH), .W(W), .KW(KW), .SHW(SHW), .PW(PW), .INT_LIM(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
    .pos_d(pos_d), .pos(pos),
    .kp_n(kp_n), .ki_n(ki_n), .kd_n(kd_n),
    .kp_d(kp_d), .ki_d(ki_d), .kd_d(kd_d),
    .clear_int(clear_int),
    .pwm(pwm), .dir(dir), .busy(busy), .done(done), .overrun(overrun)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic setChannel(input int c, input int pd, input int p,
                            input int kpn, input int kpd, input int kin,
                            input int kid, input int kdn, input int kdd);
    pos_d[c*W +: W]    = pd[W-1:0];
    pos[c*W +: W]      = p[W-1:0];
    kp_n[c*KW +: KW]   = kpn[KW-1:0];
    ki_n[c*KW +: KW]   = kin[KW-1:0];
    kd_n[c*KW +: KW]   = kdn[KW-1:0];
    kp_d[c*SHW +: SHW] = kpd[SHW-1:0];
    ki_d[c*SHW +: SHW] = kid[SHW-1:0];
    kd_d[c*SHW +: SHW] = kdd[SHW-1:0];
  endtask

  task automatic clearModel();
    for (int c = 0; c < NCH; c++) begin
      mInt[c]  = 0;
      mPrev[c] = 0;
    end
  endtask

  task automatic pushExpected();
    exp_t   e;
    longint err, der, tp, ti, td, s, mag;
    e.pwm = '0;
    e.dir = '0;
    for (int c = 0; c < NCH; c++) begin
      err = longint'(pos_d[c*W +: W]) - longint'(pos[c*W +: W]);
      if (clear_int[c]) mInt[c] = 0;
      mInt[c] = mInt[c] + err;
      if (mInt[c] > LIM)  mInt[c] = LIM;
      if (mInt[c] < -LIM) mInt[c] = -LIM;
      der      = err - mPrev[c];
      mPrev[c] = err;
      tp = (longint'(kp_n[c*KW +: KW]) * err)     >>> kp_d[c*SHW +: SHW];
      ti = (longint'(ki_n[c*KW +: KW]) * mInt[c]) >>> ki_d[c*SHW +: SHW];
      td = (longint'(kd_n[c*KW +: KW]) * der)     >>> kd_d[c*SHW +: SHW];
      s   = tp + ti + td;
      mag = (s < 0) ? -s : s;
      if (mag > PMAX) mag = PMAX;
      e.pwm[c*PW +: PW] = mag[PW-1:0];
      e.dir[c]          = (s > 0);
    end
    sbQ.push_back(e);
  endtask

  task automatic compareScoreboard();
    exp_t e;
    if (sbQ.size() == 0) begin
      checkOutput("sbUnexpectedDone", 1, 0);
    end else begin
      e = sbQ.pop_front();
      checkOutput("sbPwm", longint'(pwm), longint'(e.pwm));
      checkOutput("sbDir", longint'(dir), longint'(e.dir));
    end
  endtask

  // Runs one frame; extraTickAt/dropAt (cycles after T0, -1 = unused) inject
  // a tick while busy or drop enable mid-frame.
  task automatic applyStimulus(input int extraTickAt, input int dropAt);
    int doneAt;
    bit sawOverrun;
    doneAt     = -1;
    sawOverrun = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    if (dropAt < 0) pushExpected();
    @(posedge clk);
    #1 sample_tick = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == extraTickAt) sample_tick = 1'b1;
      if (i == dropAt)      enable = 1'b0;
      @(posedge clk);
      #1 sample_tick = 1'b0;
      if (dropAt < 0 && (i == 1 || i == 20)) checkOutput("busyDuring", busy, 1);
      if (dropAt < 0 && i == 21)             checkOutput("busyAfterCommit", busy, 0);
      if (overrun) sawOverrun = 1'b1;
      if (done && doneAt < 0) begin
        doneAt = i;
        compareScoreboard();
      end
    end
    if (dropAt < 0) begin
      checkOutput("doneLatency", doneAt, 21);
      checkOutput("overrunSeen", sawOverrun, (extraTickAt > 0) ? 1 : 0);
    end else begin
      checkOutput("abortNoDone", doneAt, -1);
      checkOutput("abortPwm", longint'(pwm), 0);
      checkOutput("abortDir", longint'(dir), 0);
      checkOutput("abortBusy", busy, 0);
      clearModel();
      enable = 1'b1;
    end
  endtask

  int planCh2 [5] = '{100, 200, 250, 250, 100};
  int planCh3 [5] = '{0, 100, 0, 0, 0};

  initial begin
    bit sawDone;
    rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0;
    pos_d = '0; pos = '0; kp_n = '0; ki_n = '0; kd_n = '0;
    kp_d = '0; ki_d = '0; kd_d = '0; clear_int = '0;
    clearModel();

    #23;
    checkOutput("rstPwm", longint'(pwm), 0);
    checkOutput("rstDir", longint'(dir), 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Directed frames: P-only ch0, negative with shift ch1, integral clamp ch2, derivative ch3.
    setChannel(0, 100, 0,   1, 0, 0, 0, 0, 0);
    setChannel(1, 0,   300, 3, 1, 0, 0, 0, 0);
    setChannel(2, 100, 0,   0, 0, 1, 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      setChannel(3, (f == 0) ? 0 : 50, 0, 0, 0, 0, 0, 2, 0);
      clear_int = (f == 4) ? 4'b0100 : 4'b0000;
      applyStimulus(-1, -1);
      checkOutput("ch0Pwm", longint'(pwm[0*PW +: PW]), 100);
      checkOutput("ch0Dir", dir[0], 1);
      checkOutput("ch1Pwm", longint'(pwm[1*PW +: PW]), 450);
      checkOutput("ch1Dir", dir[1], 0);
      checkOutput("ch2Pwm", longint'(pwm[2*PW +: PW]), planCh2[f]);
      checkOutput("ch3Pwm", longint'(pwm[3*PW +: PW]), planCh3[f]);
    end
    clear_int = '0;

    // Random frames exercise all gains, shifts and clears together.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < NCH; c++)
        setChannel(c, $urandom_range(0, 8191), $urandom_range(0, 8191),
                   $urandom_range(0, 8191), $urandom_range(0, 15),
                   $urandom_range(0, 8191), $urandom_range(0, 15),
                   $urandom_range(0, 8191), $urandom_range(0, 15));
      clear_int = 4'($urandom_range(0, 15));
      applyStimulus(-1, -1);
    end
    clear_int = '0;

    // Saturation with a tick while busy, then an aborted frame, then recovery.
    setChannel(0, 4000, 0, 8191, 0, 0, 0, 0, 0);
    applyStimulus(5, -1);
    checkOutput("satPwm0", longint'(pwm[0*PW +: PW]), 8191);
    applyStimulus(-1, 10);
    applyStimulus(-1, -1);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arstPwm", longint'(pwm), 0);
    checkOutput("arstDir", longint'(dir), 0);
    checkOutput("arstBusy", busy, 0);
    clearModel();
    sawDone = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (done) sawDone = 1'b1;
    end
    checkOutput("arstNoDone", sawDone, 0);

    // A tick with enable low starts nothing and raises no overrun.
    enable = 1'b0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("disabledBusy", busy, 0);
    checkOutput("disabledOverrun", overrun, 0);

    checkOutput("sbDrained", sbQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
